// File: rtl/studio2_pkg.sv
// Shared definitions for the Studio II keypad block: PS/2 scan-code tables,
// the key-cell state enum and the default key-select port.
package studio2_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE    = 2'd0,
        KEY_DOWN    = 2'd1,
        KEY_STRETCH = 2'd2
    } key_state_e;

    localparam int         NUM_KEYS         = 10;
    localparam logic [2:0] SEL_PORT_DEFAULT = 3'd2;
    localparam logic [3:0] SEL_RESET        = 4'hF;

    // Key n lives in bits [8n+7:8n]; key 0 is the least significant byte.
    localparam logic [79:0] KP1_CODES = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                         8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
    localparam logic [79:0] KP2_CODES = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
                                         8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};

    // One-hot (or zero) vector of the keys whose scan code equals code.
    function automatic logic [NUM_KEYS-1:0] code_match(input logic [7:0]  code,
                                                       input logic [79:0] tbl);
        logic [NUM_KEYS-1:0] hit;
        hit = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            hit[k] = (tbl[k*8 +: 8] == code);
        end
        return hit;
    endfunction

endpackage

// File: rtl/studio2_keypad_if.sv
// Signal bundle around the keypad block: PS/2 key events and the CPU OUT bus
// in one direction, EF flags and debug key state in the other.
interface studio2_keypad_if;
    logic [10:0] ps2_key;
    logic        io_out;
    logic [2:0]  io_n;
    logic [7:0]  io_dout;
    logic        ef3;
    logic        ef4;
    logic [9:0]  kp1_state;
    logic [9:0]  kp2_state;

    modport master (
        output ps2_key, io_out, io_n, io_dout,
        input  ef3, ef4, kp1_state, kp2_state
    );

    modport slave (
        input  ps2_key, io_out, io_n, io_dout,
        output ef3, ef4, kp1_state, kp2_state
    );
endinterface

// File: rtl/studio2_key_cell.sv
// One keypad key: make/break FSM plus a hold counter that keeps the key
// reading pressed for at least HOLD_CYCLES clocks after its make event, so
// short PS/2 taps are still seen by software polling EF3/EF4.
module studio2_key_cell
    import studio2_pkg::*;
#(
    parameter int HOLD_CYCLES = 100000
) (
    input  logic clk,
    input  logic resetq,
    input  logic make_i,
    input  logic break_i,
    output logic pressed_o
);
    localparam int                CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next state: a make always wins and restarts the hold window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q != KEY_IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        case (state_q)
            KEY_DOWN: begin
                if (break_i) begin
                    state_d = (cnt_q == '0) ? KEY_IDLE : KEY_STRETCH;
                end
            end
            KEY_STRETCH: begin
                if (cnt_q == '0) begin
                    state_d = KEY_IDLE;
                end
            end
            default: ;
        endcase
        if (make_i) begin
            state_d = KEY_DOWN;
            cnt_d   = CNT_LOAD;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed_o = (state_q != KEY_IDLE);

endmodule

// File: rtl/studio2_keypad.sv
// Studio II dual hex keypad emulation from a PS/2 keyboard. PS/2 events are
// decoded into per-key make/break pulses for 20 key cells; the CPU selects a
// key through an OUT port and reads it back on EF3 (pad 1) / EF4 (pad 2).
module studio2_keypad
    import studio2_pkg::*;
#(
    parameter int         HOLD_CYCLES = 100000,
    parameter logic [2:0] SEL_PORT    = SEL_PORT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [10:0] ps2_key,
    input  logic        io_out,
    input  logic [2:0]  io_n,
    input  logic [7:0]  io_dout,
    output logic        ef3,
    output logic        ef4,
    output logic [9:0]  kp1_state,
    output logic [9:0]  kp2_state
);
    logic                tog_q;
    logic [3:0]          sel_q, sel_d;
    logic                ef3_q, ef3_d;
    logic                ef4_q, ef4_d;
    logic                key_valid;
    logic [NUM_KEYS-1:0] hit1, hit2;
    logic [NUM_KEYS-1:0] make1, make2, brk1, brk2;
    logic [15:0]         kp1_pad, kp2_pad;
    logic                unused_dout_hi;

    // Turn a fresh, non-extended PS/2 toggle into per-key make/break pulses.
    always_comb begin
        key_valid = (ps2_key[10] != tog_q) && !ps2_key[8];
        hit1      = key_valid ? code_match(ps2_key[7:0], KP1_CODES) : '0;
        hit2      = key_valid ? code_match(ps2_key[7:0], KP2_CODES) : '0;
        make1     = hit1 & {NUM_KEYS{ps2_key[9]}};
        brk1      = hit1 & {NUM_KEYS{~ps2_key[9]}};
        make2     = hit2 & {NUM_KEYS{ps2_key[9]}};
        brk2      = hit2 & {NUM_KEYS{~ps2_key[9]}};
    end

    // Select latch update and EF mux; selects 10-15 land on the zero padding.
    always_comb begin
        sel_d = sel_q;
        if (io_out && io_n == SEL_PORT) begin
            sel_d = io_dout[3:0];
        end
        kp1_pad = {6'b0, kp1_state};
        kp2_pad = {6'b0, kp2_state};
        ef3_d   = kp1_pad[sel_q];
        ef4_d   = kp2_pad[sel_q];
    end

    // Toggle history keeps tracking during reset so release creates no event.
    always_ff @(posedge clk) begin
        tog_q <= ps2_key[10];
        if (!resetq) begin
            sel_q <= SEL_RESET;
            ef3_q <= 1'b0;
            ef4_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            ef3_q <= ef3_d;
            ef4_q <= ef4_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            studio2_key_cell #(
                .HOLD_CYCLES (HOLD_CYCLES)
            ) u_kp1 (
                .clk       (clk),
                .resetq    (resetq),
                .make_i    (make1[gi]),
                .break_i   (brk1[gi]),
                .pressed_o (kp1_state[gi])
            );
            studio2_key_cell #(
                .HOLD_CYCLES (HOLD_CYCLES)
            ) u_kp2 (
                .clk       (clk),
                .resetq    (resetq),
                .make_i    (make2[gi]),
                .break_i   (brk2[gi]),
                .pressed_o (kp2_state[gi])
            );
        end
    endgenerate

    assign ef3            = ef3_q;
    assign ef4            = ef4_q;
    assign unused_dout_hi = ^io_dout[7:4];

endmodule
